// File: rtl/mmr_irq_ctrl_pkg.sv
// ============================================================================
// Module      : mmr_config (package)
// Description : Shared MMR offsets, sizes and the interrupt-window decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmr_config;

    localparam int NGEMQUEUES      = 2;
    localparam int MMR_RANGE_WIDTH = 10;

    localparam logic [MMR_RANGE_WIDTH-1:0] REGOFF_IER_BASE = 10'h100;
    localparam logic [MMR_RANGE_WIDTH-1:0] REGOFF_IDR_BASE = 10'h120;
    localparam logic [MMR_RANGE_WIDTH-1:0] REGOFF_IMR_BASE = 10'h140;
    localparam logic [MMR_RANGE_WIDTH-1:0] REGOFF_ISR_BASE = 10'h160;

    // Each bank spans 32 bytes: 8 word-aligned queue slots.
    localparam logic [MMR_RANGE_WIDTH-1:0] BANK_MASK = 10'h3E0;

    typedef enum logic [2:0] {
        IRQ_IER  = 3'd0,
        IRQ_IDR  = 3'd1,
        IRQ_IMR  = 3'd2,
        IRQ_ISR  = 3'd3,
        IRQ_NONE = 3'd4
    } irq_reg_kind_t;

    typedef struct packed {
        irq_reg_kind_t kind;
        logic [2:0]    queue;
    } irq_decode_t;

    // Queue-count bounds are the caller's job; this only knows the map shape.
    function automatic irq_decode_t regoff_irq_decode(input logic [MMR_RANGE_WIDTH-1:0] addr);
        irq_decode_t                 d;
        logic [MMR_RANGE_WIDTH-1:0]  bank;
        bank    = addr & BANK_MASK;
        d.kind  = IRQ_NONE;
        d.queue = addr[4:2];
        if (addr[1:0] == 2'b00) begin
            if (bank == REGOFF_IER_BASE)      d.kind = IRQ_IER;
            else if (bank == REGOFF_IDR_BASE) d.kind = IRQ_IDR;
            else if (bank == REGOFF_IMR_BASE) d.kind = IRQ_IMR;
            else if (bank == REGOFF_ISR_BASE) d.kind = IRQ_ISR;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmr_irq_queue.sv
// ============================================================================
// Module      : mmr_irq_queue
// Description : IMR/ISR state and registered interrupt line for one queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_irq_queue #(
    parameter int NBITS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ier_we_i,
    input  logic             idr_we_i,
    input  logic             isr_re_i,
    input  logic [NBITS-1:0] wdata_i,
    input  logic [NBITS-1:0] event_set_i,
    output logic [NBITS-1:0] imr_o,
    output logic [NBITS-1:0] isr_o,
    output logic             irq_o
);

    logic [NBITS-1:0] imr_q, imr_d;
    logic [NBITS-1:0] isr_q, isr_d;
    logic             irq_q, irq_d;

    always_comb begin
        imr_d = imr_q;
        if (ier_we_i) imr_d = imr_d & ~wdata_i;
        if (idr_we_i) imr_d = imr_d | wdata_i;

        // Events are OR-ed after the read clear so a coincident event survives.
        isr_d = isr_q;
        if (isr_re_i) isr_d = '0;
        isr_d = isr_d | event_set_i;

        irq_d = |(isr_d & ~imr_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imr_q <= '1;
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            imr_q <= imr_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end

    assign imr_o = imr_q;
    assign isr_o = isr_q;
    assign irq_o = irq_q;

endmodule

`default_nettype wire

// File: rtl/mmr_irq_ctrl.sv
// ============================================================================
// Module      : mmr_irq_ctrl
// Description : Per-queue IER/IDR/IMR/ISR interrupt controller behind the MMR decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_irq_ctrl
    import mmr_config::*;
#(
    parameter int NQUEUES = NGEMQUEUES,
    parameter int NBITS   = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mmr_req,
    input  logic                       mmr_we,
    input  logic [MMR_RANGE_WIDTH-1:0] mmr_addr,
    input  logic [NBITS-1:0]           mmr_wdata,
    output logic                       mmr_rvalid,
    output logic [NBITS-1:0]           mmr_rdata,
    output logic                       mmr_err,
    input  logic [NQUEUES*NBITS-1:0]   event_set,
    output logic [NQUEUES-1:0]         irq
);

    irq_decode_t       dec;
    logic              hit;
    logic [NQUEUES-1:0] ier_we, idr_we, isr_re;
    logic [NBITS-1:0]  imr   [NQUEUES];
    logic [NBITS-1:0]  isr   [NQUEUES];
    logic [NBITS-1:0]  rdata_sel;

    logic              rvalid_q;
    logic [NBITS-1:0]  rdata_q;
    logic              err_q;

    always_comb begin
        dec       = regoff_irq_decode(mmr_addr);
        hit       = (dec.kind != IRQ_NONE) && (int'(dec.queue) < NQUEUES);
        ier_we    = '0;
        idr_we    = '0;
        isr_re    = '0;
        rdata_sel = '0;
        for (int q = 0; q < NQUEUES; q++) begin
            if (hit && (int'(dec.queue) == q)) begin
                ier_we[q] = mmr_req &  mmr_we & (dec.kind == IRQ_IER);
                idr_we[q] = mmr_req &  mmr_we & (dec.kind == IRQ_IDR);
                isr_re[q] = mmr_req & ~mmr_we & (dec.kind == IRQ_ISR);
                // IER/IDR read as zero; the ISR value is sampled before any clear.
                if (dec.kind == IRQ_IMR)      rdata_sel = imr[q];
                else if (dec.kind == IRQ_ISR) rdata_sel = isr[q];
            end
        end
    end

    for (genvar g = 0; g < NQUEUES; g++) begin : g_queue
        mmr_irq_queue #(
            .NBITS (NBITS)
        ) u_queue (
            .clock       (clock),
            .reset       (reset),
            .ier_we_i    (ier_we[g]),
            .idr_we_i    (idr_we[g]),
            .isr_re_i    (isr_re[g]),
            .wdata_i     (mmr_wdata),
            .event_set_i (event_set[g*NBITS +: NBITS]),
            .imr_o       (imr[g]),
            .isr_o       (isr[g]),
            .irq_o       (irq[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= mmr_req & ~mmr_we;
            err_q    <= mmr_req & ~hit;
            if (mmr_req && !mmr_we) rdata_q <= rdata_sel;
        end
    end

    assign mmr_rvalid = rvalid_q;
    assign mmr_rdata  = rdata_q;
    assign mmr_err    = err_q;

endmodule

`default_nettype wire
